// File: rtl/memory_read_control_pkg.sv
// Shared memory constants: read-FSM state encodings, writer step, RAM access-type codes.
package memory_read_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PEND    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } rd_state_e;

    // Process step during which the RAM port belongs to the writer.
    localparam logic [2:0] WRITE_STEP_DEFAULT = 3'b100;

    typedef enum logic [1:0] {
        ACC_TYPE_0 = 2'd0,
        ACC_TYPE_1 = 2'd1,
        ACC_TYPE_2 = 2'd2,
        ACC_TYPE_3 = 2'd3
    } access_type_e;

    // Location index is {p2, type}; a sweep visits 0..LOC_LAST.
    localparam logic [2:0] LOC_FIRST = {1'b0, ACC_TYPE_0};
    localparam logic [2:0] LOC_LAST  = {1'b1, ACC_TYPE_3};

endpackage

// File: rtl/memory_read_control_latency_counter.sv
// Read latency countdown: loaded at issue, decremented while waiting on the RAM.
module read_latency_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // The decrement that takes the count to zero is the last wait cycle.
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/memory_read_control.sv
// Read side of the shared score RAM: single reads or an 8-location sweep, yielding the port on writer steps.
module memory_read_control
    import memory_read_control_pkg::*;
#(
    parameter int         RD_LATENCY = 2,
    parameter logic [2:0] WRITE_STEP = WRITE_STEP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        sweep,
    input  logic        req_p2,
    input  logic [1:0]  req_type,
    input  logic [2:0]  process,
    input  logic [7:0]  ram_result,
    output logic        access_p2,
    output logic [1:0]  access_type,
    output logic        wren,
    output logic        rd_active,
    output logic [10:0] memory_out,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

    rd_state_e  state_q, state_d;
    logic [2:0] loc_q;
    logic       sweep_q;
    logic [2:0] proc_q;
    logic       write_step;
    logic [1:0] lat_count;
    logic       lat_last;

    assign write_step = (process == WRITE_STEP);
    assign wren       = 1'b0;

    read_latency_counter #(.WIDTH(2)) u_lat (
        .clock      (clock),
        .reset      (reset),
        .load       ((state_q == ST_ISSUE) && !write_step),
        .load_value (LAT_LOAD),
        .dec        ((state_q == ST_WAIT) && !write_step),
        .count      (lat_count),
        .last       (lat_last)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no branch can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (req) state_d = ST_PEND;
            ST_PEND:    if (!write_step) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (write_step)           state_d = ST_PEND;
                else if (RD_LATENCY == 1) state_d = ST_CAPTURE;
                else                      state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (write_step)    state_d = ST_PEND;
                else if (lat_last) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = (sweep_q && (loc_q != LOC_LAST)) ? ST_PEND : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // The port is released combinationally the moment the writer step appears.
    always_comb begin
        rd_active   = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !write_step;
        busy        = (state_q != ST_IDLE);
        access_p2   = rd_active ? loc_q[2]   : 1'b0;
        access_type = rd_active ? loc_q[1:0] : ACC_TYPE_0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            loc_q      <= LOC_FIRST;
            sweep_q    <= 1'b0;
            proc_q     <= 3'b000;
            memory_out <= 11'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        sweep_q <= sweep;
                        loc_q   <= sweep ? LOC_FIRST : {req_p2, req_type};
                    end
                end
                ST_ISSUE: begin
                    if (!write_step) proc_q <= process;
                end
                ST_CAPTURE: begin
                    memory_out <= {proc_q, ram_result};
                    out_valid  <= 1'b1;
                    if (sweep_q) begin
                        loc_q <= loc_q + 3'd1;
                        done  <= (loc_q == LOC_LAST);
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_read_control.sv
// Directed bench for memory_read_control with a 2-cycle-latency RAM model.
module tb_memory_read_control;

    logic        clock = 1'b0;
    logic        reset, req, sweep, req_p2;
    logic [1:0]  req_type;
    logic [2:0]  process;
    logic [7:0]  ram_result;
    logic        access_p2;
    logic [1:0]  access_type;
    logic        wren, rd_active, out_valid, busy, done;
    logic [10:0] memory_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [8];
    logic [2:0] a1, a2;

    always #5 clock = ~clock;

    memory_read_control #(.RD_LATENCY(2), .WRITE_STEP(3'b100)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .sweep       (sweep),
        .req_p2      (req_p2),
        .req_type    (req_type),
        .process     (process),
        .ram_result  (ram_result),
        .access_p2   (access_p2),
        .access_type (access_type),
        .wren        (wren),
        .rd_active   (rd_active),
        .memory_out  (memory_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    // RAM: address registered twice, data valid two cycles after presentation.
    always @(posedge clock) begin
        a1 <= {access_p2, access_type};
        a2 <= a1;
    end
    assign ram_result = mem[a2];

    // Port must never be owned during the writer step.
    always @(negedge clock) begin
        #2;
        if (process == 3'b100 && reset === 1'b0) begin
            checks++;
            if (rd_active !== 1'b0) begin
                failures++;
                $display("FAIL write_step_owned: rd_active=%b want 0", rd_active);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; req = 1'b1; sweep = 1'b0; req_p2 = 1'b1; req_type = 2'd3; process = 3'b001;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL reset_rd_active: got %b want 0", rd_active); end
        checks++; if (memory_out !== 11'h000) begin failures++; $display("FAIL reset_memory_out: got %h want 000", memory_out); end
        checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_pulses: out_valid=%b done=%b want 0 0", out_valid, done); end
        checks++; if ({access_p2, access_type} !== 3'b000) begin failures++; $display("FAIL reset_access: got %b want 000", {access_p2, access_type}); end
        checks++; if (wren !== 1'b0) begin failures++; $display("FAIL reset_wren: got %b want 0", wren); end
        @(negedge clock);
        reset = 1'b0; req = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_priority: busy=%b want 0", busy); end
        @(negedge clock); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_hold: busy=%b want 0", busy); end
    endtask

    task automatic test_single();
        int n, lat;
        @(negedge clock);
        process = 3'b001; req_p2 = 1'b1; req_type = 2'b10; sweep = 1'b0; req = 1'b1;
        @(negedge clock);
        req = 1'b0; #1;
        checks++; if (busy !== 1'b1 || rd_active !== 1'b0) begin failures++; $display("FAIL single_pend: busy=%b rd_active=%b want 1 0", busy, rd_active); end
        n = 0;
        while (rd_active !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
        checks++; if (n !== 1) begin failures++; $display("FAIL single_issue_time: cycles=%0d want 1", n); end
        checks++; if ({access_p2, access_type} !== 3'b110) begin failures++; $display("FAIL single_address: got %b want 110", {access_p2, access_type}); end
        lat = 0;
        do begin @(negedge clock); #1; lat++; end while (out_valid !== 1'b1 && lat < 20);
        checks++; if (lat !== 3) begin failures++; $display("FAIL single_latency: got %0d want 3", lat); end
        checks++; if (memory_out !== 11'b001_1010_0101) begin failures++; $display("FAIL single_data: got %h want 1a5", memory_out); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_done: done=%b busy=%b want 1 0", done, busy); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL single_pulse_width: out_valid=%b done=%b want 0 0", out_valid, done); end
        checks++; if (memory_out !== 11'h1a5) begin failures++; $display("FAIL single_hold: got %h want 1a5", memory_out); end
    endtask

    task automatic test_write_step_hold();
        int lat;
        @(negedge clock);
        process = 3'b100; req_p2 = 1'b0; req_type = 2'd1; req = 1'b1; #1;
        checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL hold_cycle0: rd_active=%b want 0", rd_active); end
        for (int i = 1; i < 5; i++) begin
            @(negedge clock);
            req = 1'b0; #1;
            checks++; if (rd_active !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_cycle%0d: rd_active=%b busy=%b want 0 1", i, rd_active, busy); end
        end
        @(negedge clock);
        process = 3'b010; #1;
        checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL hold_leave: rd_active=%b want 0", rd_active); end
        @(negedge clock); #1;
        checks++; if (rd_active !== 1'b1 || {access_p2, access_type} !== 3'b001) begin failures++; $display("FAIL hold_issue: rd_active=%b addr=%b want 1 001", rd_active, {access_p2, access_type}); end
        lat = 0;
        do begin @(negedge clock); #1; lat++; end while (out_valid !== 1'b1 && lat < 20);
        checks++; if (lat !== 3 || memory_out !== 11'h23c) begin failures++; $display("FAIL hold_result: latency=%0d data=%h want 3 23c", lat, memory_out); end
    endtask

    task automatic test_abort();
        int lat;
        @(negedge clock);
        process = 3'b011; req_p2 = 1'b1; req_type = 2'd1; req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock); #1;
        checks++; if (rd_active !== 1'b1) begin failures++; $display("FAIL abort_issue: rd_active=%b want 1", rd_active); end
        @(negedge clock);
        process = 3'b100; #1;
        checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL abort_drop: rd_active=%b want 0", rd_active); end
        @(negedge clock);
        process = 3'b110; #1;
        checks++; if (out_valid !== 1'b0 || rd_active !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_pend: out_valid=%b rd_active=%b busy=%b want 0 0 1", out_valid, rd_active, busy); end
        @(negedge clock); #1;
        checks++; if (rd_active !== 1'b1 || {access_p2, access_type} !== 3'b101 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_retry: rd_active=%b addr=%b out_valid=%b want 1 101 0", rd_active, {access_p2, access_type}, out_valid); end
        lat = 0;
        do begin @(negedge clock); #1; lat++; end while (out_valid !== 1'b1 && lat < 20);
        checks++; if (lat !== 3 || memory_out !== 11'h65a || done !== 1'b1) begin failures++; $display("FAIL abort_result: latency=%0d data=%h done=%b want 3 65a 1", lat, memory_out, done); end
    endtask

    task automatic test_sweep();
        int k, n, dn;
        logic [10:0] exp_word;
        @(negedge clock);
        process = 3'b001; sweep = 1'b1; req_p2 = 1'b1; req_type = 2'd3; req = 1'b1;
        k = 0; n = 0; dn = 0;
        while (k < 8 && n < 100) begin
            @(negedge clock);
            req = 1'b0; sweep = 1'b0; #1; n++;
            if (done === 1'b1) dn++;
            if (out_valid === 1'b1) begin
                exp_word = {3'b001, 8'h10 + 8'(k)};
                checks++; if (memory_out !== exp_word) begin failures++; $display("FAIL sweep_word%0d: got %h want %h", k, memory_out, exp_word); end
                checks++; if (done !== (k == 7)) begin failures++; $display("FAIL sweep_done%0d: got %b want %b", k, done, (k == 7)); end
                k++;
            end
        end
        checks++; if (k !== 8 || dn !== 1) begin failures++; $display("FAIL sweep_count: words=%0d dones=%0d want 8 1", k, dn); end
        @(negedge clock); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL sweep_end: busy=%b out_valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_mid_sweep();
        int n, pv;
        @(negedge clock);
        process = 3'b001; sweep = 1'b1; req = 1'b1;
        n = 0; pv = 0;
        do begin
            @(negedge clock);
            req = 1'b0; sweep = 1'b0; #1; n++;
            if (out_valid === 1'b1) pv++;
        end while (!(rd_active === 1'b1 && {access_p2, access_type} === 3'd3) && n < 100);
        checks++; if (pv !== 3 || n >= 100) begin failures++; $display("FAIL midsweep_reach: words=%0d cycles=%0d want 3 <100", pv, n); end
        @(negedge clock); #1;
        checks++; if (rd_active !== 1'b1) begin failures++; $display("FAIL midsweep_wait: rd_active=%b want 1", rd_active); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; #1;
        checks++; if (memory_out !== 11'h000 || out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midsweep_reset_regs: data=%h out_valid=%b done=%b want 000 0 0", memory_out, out_valid, done); end
        checks++; if (rd_active !== 1'b0 || busy !== 1'b0 || {access_p2, access_type} !== 3'b000) begin failures++; $display("FAIL midsweep_reset_ctrl: rd_active=%b busy=%b addr=%b want 0 0 000", rd_active, busy, {access_p2, access_type}); end
        pv = 0;
        repeat (20) begin @(negedge clock); #1; if (out_valid === 1'b1 || done === 1'b1 || busy === 1'b1) pv++; end
        checks++; if (pv !== 0) begin failures++; $display("FAIL midsweep_quiet: active cycles=%0d want 0", pv); end
    endtask

    task automatic test_back_to_back_req();
        int dn, ov;
        @(negedge clock);
        process = 3'b001; sweep = 1'b0; req_p2 = 1'b0; req_type = 2'd2; req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        req_p2 = 1'b1; req_type = 2'd3; req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        dn = 0; ov = 0;
        repeat (15) begin
            @(negedge clock); #1;
            if (done === 1'b1) dn++;
            if (out_valid === 1'b1) ov++;
        end
        checks++; if (dn !== 1 || ov !== 1) begin failures++; $display("FAIL busy_req_ignored: dones=%0d words=%0d want 1 1", dn, ov); end
        checks++; if (memory_out !== 11'h177 || busy !== 1'b0) begin failures++; $display("FAIL busy_req_data: data=%h busy=%b want 177 0", memory_out, busy); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        test_reset();
        mem[6] = 8'hA5;
        test_single();
        mem[1] = 8'h3C;
        test_write_step_hold();
        mem[5] = 8'h5A;
        test_abort();
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        test_sweep();
        test_reset_mid_sweep();
        mem[2] = 8'h77;
        test_back_to_back_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_read_control.md
MEMORY_READ_CONTROL -- requirements
Module: memory_read_control

Interface
REQ-001 Parameter RD_LATENCY, default 2, SHALL be the RAM read latency in clock cycles from address presentation to valid ram_result (legal 1..3).
REQ-002 Parameter WRITE_STEP, default 3'b100, SHALL be the process step during which the RAM port belongs to the writer.
REQ-003 clock  input  1  SHALL be the single system clock (CLOCK_50 at top level).
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  1  SHALL request a read; sampled only in IDLE.
REQ-006 sweep  input  1  SHALL, when sampled with req, select sweep mode: all 8 locations, player 1 then player 2, types 0..3.
REQ-007 req_p2  input  1  SHALL select the player for a single read.
REQ-008 req_type  input  2  SHALL select the access type for a single read.
REQ-009 process  input  3  SHALL be the current transaction step from the transaction controller.
REQ-010 ram_result  input  8  SHALL be the RAM read data.
REQ-011 access_p2  output  1  SHALL drive the RAM player-select while rd_active.
REQ-012 access_type  output  2  SHALL drive the RAM access-type select while rd_active.
REQ-013 wren  output  1  SHALL be constant 0.
REQ-014 rd_active  output  1  SHALL tell the top-level mux this block owns the RAM port.
REQ-015 memory_out  output  11  SHALL present {process captured at issue, data}.
REQ-016 out_valid  output  1  SHALL pulse high one cycle per captured word.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.
REQ-018 done  output  1  SHALL pulse high one cycle when a single read or full sweep completes.

Function
REQ-019 FSM states SHALL be IDLE, PEND, ISSUE, WAIT, CAPTURE.
REQ-020 IDLE: req=1 SHALL latch req_p2/req_type (or player 0, type 0 if sweep) and go to PEND next cycle.
REQ-021 PEND: process != WRITE_STEP SHALL go to ISSUE; else remain in PEND.
REQ-022 ISSUE: SHALL assert rd_active with the latched address, latch process, load latency counter with RD_LATENCY-1, go to WAIT (or to CAPTURE directly when RD_LATENCY=1).
REQ-023 WAIT: rd_active and address SHALL hold; counter decrements each cycle; go to CAPTURE when counter reaches 0.
REQ-024 CAPTURE: ram_result SHALL be registered into memory_out[7:0] with the latched process in [10:8], out_valid pulsed in the following cycle.
REQ-025 Issue-to-out_valid latency SHALL be exactly RD_LATENCY+1 cycles with no write-step conflict.
REQ-026 rd_active SHALL never be high in any cycle where process == WRITE_STEP.
REQ-027 process entering WRITE_STEP during ISSUE or WAIT SHALL abort the read: rd_active drops the same cycle, no out_valid, return to PEND, same address retried.
REQ-028 After CAPTURE in sweep mode the location index (3-bit, {p2,type}) SHALL increment and return to PEND; after index 7 it SHALL return to IDLE with done.
REQ-029 Single read SHALL return to IDLE with done coincident with out_valid.
REQ-030 req while busy SHALL be ignored (no queueing).
REQ-031 memory_out SHALL hold its last value until the next capture.

Reset
REQ-032 reset SHALL force IDLE, counters 0, memory_out 11'b0, out_valid 0, done 0, rd_active 0, access_p2 0, access_type 2'b00, latched process 3'b000.
REQ-033 reset mid-read or mid-sweep SHALL discard the operation with no out_valid or done thereafter.
REQ-034 reset and req in the same cycle SHALL give reset priority.

Structure
REQ-035 State encodings, WRITE_STEP and the access-type codes SHALL live in the shared memory constants package used by the writer side.
REQ-036 The latency countdown SHALL be one sub-module, read_latency_counter; all else in one module.

Verification
REQ-037 Single read, process=3'b001, req_p2=1, req_type=2'b10, RAM returns 8'hA5 -> out_valid 3 cycles after ISSUE, memory_out=11'b001_1010_0101, done same cycle.
REQ-038 req with process=3'b100 held 5 cycles -> rd_active stays 0 for those 5 cycles, ISSUE occurs the cycle after process leaves 3'b100.
REQ-039 process goes to 3'b100 in WAIT -> rd_active drops same cycle, no out_valid, read retried later and completes with correct data.
REQ-040 Sweep with RAM holding 8'h10..8'h17 -> eight out_valid pulses in order 10..17, done only with the eighth.
REQ-041 reset asserted in WAIT of sweep index 3 -> all outputs at reset values next cycle, no further out_valid.
REQ-042 req pulsed while busy -> ignored, only one done observed.
